// File: rtl/pong_defs.sv
// Shared encodings for the pong game-flow logic: FSM states and serve directions.
package pong_defs;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StServeWait = 3'd1,
    StRally     = 3'd2,
    StPoint     = 3'd3,
    StGameOver  = 3'd4
  } state_e;

  localparam logic DirP1 = 1'b0;
  localparam logic DirP2 = 1'b1;

endpackage

// File: rtl/match_fsm_rise_detect.sv
// Registered rising-edge detector: one-cycle pulse the edge after the input goes high.
module rise_detect (
  input  logic mclk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  // Cleared history means a level already high at reset release still counts as an edge.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      sig_q <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sig_q <= sig;
      rise  <= sig & ~sig_q;
    end
  end

endmodule

// File: rtl/match_fsm.sv
// Pong match controller: scores, serve timing and idle/serve/rally/point/game-over sequencing.
module match_fsm
  import pong_defs::*;
#(
  parameter int unsigned SCORE_BITS  = 3,
  parameter int unsigned WIN_SCORE   = 5,
  parameter int unsigned SERVE_DELAY = 60,
  parameter int unsigned CNT_BITS    = 8
) (
  input  logic                  mclk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  start,
  input  logic                  point1,
  input  logic                  point2,
  output logic [SCORE_BITS-1:0] score1,
  output logic [SCORE_BITS-1:0] score2,
  output logic                  playing,
  output logic                  winner,
  output logic                  freeze,
  output logic                  serve,
  output logic                  serve_dir,
  output logic [2:0]            state_dbg
);

  localparam logic [CNT_BITS-1:0]   CntMax   = CNT_BITS'(SERVE_DELAY);
  localparam logic [SCORE_BITS-1:0] ScoreWin = SCORE_BITS'(WIN_SCORE);

  logic                start_rise, p1_rise, p2_rise;
  state_e              state_q;
  logic [CNT_BITS-1:0] cnt_q;

  rise_detect u_start_rise (.mclk(mclk), .reset(reset), .sig(start),  .rise(start_rise));
  rise_detect u_p1_rise    (.mclk(mclk), .reset(reset), .sig(point1), .rise(p1_rise));
  rise_detect u_p2_rise    (.mclk(mclk), .reset(reset), .sig(point2), .rise(p2_rise));

  assign serve     = (state_q == StServeWait) && (cnt_q == CntMax);
  assign playing   = (state_q == StServeWait) || (state_q == StRally) || (state_q == StPoint);
  assign state_dbg = state_q;

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      score1    <= '0;
      score2    <= '0;
      winner    <= 1'b0;
      freeze    <= 1'b1;
      serve_dir <= DirP2;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_rise) begin
            state_q <= StServeWait;
            cnt_q   <= '0;
          end
        end
        StServeWait: begin
          // Leaving at CntMax keeps the counter from ever running past it.
          if (serve) begin
            state_q <= StRally;
            freeze  <= 1'b0;
          end else if (tick) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRally: begin
          if (p1_rise && p2_rise) begin
            state_q <= StServeWait;
            cnt_q   <= '0;
            freeze  <= 1'b1;
          end else if (p1_rise) begin
            score1    <= score1 + 1'b1;
            serve_dir <= DirP2;
            state_q   <= StPoint;
            freeze    <= 1'b1;
          end else if (p2_rise) begin
            score2    <= score2 + 1'b1;
            serve_dir <= DirP1;
            state_q   <= StPoint;
            freeze    <= 1'b1;
          end
        end
        StPoint: begin
          if ((score1 == ScoreWin) || (score2 == ScoreWin)) begin
            state_q <= StGameOver;
            winner  <= (score1 == ScoreWin);
          end else begin
            state_q <= StServeWait;
            cnt_q   <= '0;
          end
        end
        StGameOver: begin
          if (start_rise) begin
            score1    <= '0;
            score2    <= '0;
            winner    <= 1'b0;
            serve_dir <= DirP2;
            state_q   <= StServeWait;
            cnt_q     <= '0;
          end
        end
        default: begin
          state_q <= StIdle;
          freeze  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_fsm.sv
// Bench for match_fsm: default build and a zero-serve-delay build driven in lockstep.
module tb_match_fsm;

  logic mclk = 1'b0;
  logic reset, tick, start, point1, point2;

  logic [2:0] sc1 [2];
  logic [2:0] sc2 [2];
  logic [2:0] dbg [2];
  logic       ply [2];
  logic       win [2];
  logic       frz [2];
  logic       srv [2];
  logic       dir [2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: game phase numbers as given in the state table.
  int unsigned dly [2];
  int          m_st [2];
  int          m_s1 [2];
  int          m_s2 [2];
  int          m_ticks [2];
  int          m_dir [2];
  int          m_win [2];
  bit          prev_start, prev_p1, prev_p2;
  bit          ev_start, ev_p1, ev_p2;

  always #5 mclk = ~mclk;

  match_fsm #(.SCORE_BITS(3), .WIN_SCORE(5), .SERVE_DELAY(60), .CNT_BITS(8)) u_dut0 (
    .mclk(mclk), .reset(reset), .tick(tick), .start(start), .point1(point1), .point2(point2),
    .score1(sc1[0]), .score2(sc2[0]), .playing(ply[0]), .winner(win[0]), .freeze(frz[0]),
    .serve(srv[0]), .serve_dir(dir[0]), .state_dbg(dbg[0])
  );

  match_fsm #(.SCORE_BITS(3), .WIN_SCORE(5), .SERVE_DELAY(0), .CNT_BITS(8)) u_dut1 (
    .mclk(mclk), .reset(reset), .tick(tick), .start(start), .point1(point1), .point2(point2),
    .score1(sc1[1]), .score2(sc2[1]), .playing(ply[1]), .winner(win[1]), .freeze(frz[1]),
    .serve(srv[1]), .serve_dir(dir[1]), .state_dbg(dbg[1])
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_s1[k] = 0; m_s2[k] = 0; m_ticks[k] = 0; m_dir[k] = 1; m_win[k] = 0;
    end
    prev_start = 0; prev_p1 = 0; prev_p2 = 0;
    ev_start = 0; ev_p1 = 0; ev_p2 = 0;
  endtask

  // One clock edge of the game rules; events seen now are the rises registered last edge.
  task automatic model_edge();
    bit es, e1, e2;
    es = ev_start; e1 = ev_p1; e2 = ev_p2;
    ev_start = start & ~prev_start;
    ev_p1    = point1 & ~prev_p1;
    ev_p2    = point2 & ~prev_p2;
    prev_start = start; prev_p1 = point1; prev_p2 = point2;
    for (int k = 0; k < 2; k++) begin
      case (m_st[k])
        0: if (es) begin m_st[k] = 1; m_ticks[k] = 0; end
        1: begin
          if (m_ticks[k] == int'(dly[k])) m_st[k] = 2;
          else if (tick) m_ticks[k] = m_ticks[k] + 1;
        end
        2: begin
          if (e1 && e2) begin
            m_st[k] = 1; m_ticks[k] = 0;
          end else if (e1) begin
            m_s1[k] = m_s1[k] + 1; m_dir[k] = 1; m_st[k] = 3;
          end else if (e2) begin
            m_s2[k] = m_s2[k] + 1; m_dir[k] = 0; m_st[k] = 3;
          end
        end
        3: begin
          if (m_s1[k] == 5 || m_s2[k] == 5) begin
            m_st[k] = 4; m_win[k] = (m_s1[k] == 5) ? 1 : 0;
          end else begin
            m_st[k] = 1; m_ticks[k] = 0;
          end
        end
        default: begin
          if (es) begin
            m_s1[k] = 0; m_s2[k] = 0; m_win[k] = 0; m_dir[k] = 1;
            m_st[k] = 1; m_ticks[k] = 0;
          end
        end
      endcase
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("d%0d_state", k),   8'(dbg[k]), 8'(m_st[k]));
      check($sformatf("d%0d_score1", k),  8'(sc1[k]), 8'(m_s1[k]));
      check($sformatf("d%0d_score2", k),  8'(sc2[k]), 8'(m_s2[k]));
      check($sformatf("d%0d_playing", k), 8'(ply[k]), 8'(m_st[k] >= 1 && m_st[k] <= 3));
      check($sformatf("d%0d_freeze", k),  8'(frz[k]), 8'(m_st[k] != 2));
      check($sformatf("d%0d_serve", k),   8'(srv[k]),
            8'(m_st[k] == 1 && m_ticks[k] == int'(dly[k])));
      check($sformatf("d%0d_dir", k),     8'(dir[k]), 8'(m_dir[k]));
      check($sformatf("d%0d_winner", k),  8'(win[k]), 8'(m_win[k]));
    end
  endtask

  task automatic step();
    tick = (cyc % 4 == 3);
    @(posedge mclk);
    model_edge();
    cyc++;
    #1;
    check_all();
  endtask

  // Reset asserted and checked between clock edges, so asynchronous behaviour is visible.
  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    #1 reset = 1'b0;
  endtask

  task automatic wait_st(input int st, input int bound, input string tag);
    int n = 0;
    while (m_st[0] != st && n < bound) begin
      step();
      n++;
    end
    if (m_st[0] != st) begin
      n_cmp++;
      n_bad++;
      $error("FAIL timeout_%s: observed state %0d expected %0d", tag, dbg[0], st);
    end
  endtask

  task automatic pulse(input bit p1, input bit p2, input int len);
    point1 = p1; point2 = p2;
    repeat (len) step();
    point1 = 1'b0; point2 = 1'b0;
    step();
  endtask

  initial begin
    int seen;
    dly[0] = 60; dly[1] = 0;
    reset = 1'b1; tick = 1'b0; start = 1'b0; point1 = 1'b0; point2 = 1'b0;
    #3;
    model_reset();
    check_all();
    #1 reset = 1'b0;

    // Start, then one serve after 60 ticks.
    repeat ($urandom_range(1, 5)) step();
    start = 1'b1;
    repeat (3) step();
    start = 1'b0;
    seen = 0;
    for (int n = 0; n < 400 && m_st[0] != 2; n++) begin
      step();
      if (srv[0] === 1'b1) seen++;
    end
    check("serve_once", 8'(seen), 8'd1);
    check("rally_freeze", 8'(frz[0]), 8'd0);

    // Held point1: exactly one point, two edges after the rise.
    point1 = 1'b1;
    step();
    check("p1_edge1_score", 8'(sc1[0]), 8'd0);
    step();
    check("p1_edge2_score", 8'(sc1[0]), 8'd1);
    repeat (8) step();
    point1 = 1'b0;
    check("p1_held_score", 8'(sc1[0]), 8'd1);
    check("p1_dir", 8'(dir[0]), 8'd1);
    wait_st(2, 400, "reserve");

    // Simultaneous points: no score, back to serve wait.
    point1 = 1'b1; point2 = 1'b1;
    step(); step();
    check("both_state", 8'(dbg[0]), 8'd1);
    check("both_score2", 8'(sc2[0]), 8'd0);
    point1 = 1'b0; point2 = 1'b0;

    // Player 2 wins the match.
    for (int i = 0; i < 10 && m_st[0] != 4; i++) begin
      wait_st(2, 400, "rally_p2");
      pulse(1'b0, 1'b1, $urandom_range(1, 4));
      repeat ($urandom_range(0, 2)) step();
    end
    check("go_winner", 8'(win[0]), 8'd0);
    check("go_playing", 8'(ply[0]), 8'd0);
    check("go_score2", 8'(sc2[0]), 8'd5);
    pulse(1'b1, 1'b0, 2);
    pulse(1'b0, 1'b1, 3);
    check("go_ignore_score1", 8'(sc1[0]), 8'd1);
    start = 1'b1;
    step(); step();
    start = 1'b0;
    check("restart_score2", 8'(sc2[0]), 8'd0);

    // Three points to player 1, then reset partway through serve wait.
    for (int i = 0; i < 3; i++) begin
      wait_st(2, 400, "rally_p1");
      pulse(1'b1, 1'b0, 1);
    end
    wait_st(1, 10, "sw_before_reset");
    repeat (20) step();
    check("pre_reset_score1", 8'(sc1[0]), 8'd3);
    async_reset();
    check("rst_state", 8'(dbg[0]), 8'd0);
    check("rst_score1", 8'(sc1[0]), 8'd0);
    check("rst_freeze", 8'(frz[0]), 8'd1);
    check("rst_serve", 8'(srv[0]), 8'd0);

    // Random play, including occasional mid-game resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 60) == 0) start = ~start;
      if ($urandom_range(0, 7) == 0) point1 = ~point1;
      if ($urandom_range(0, 7) == 0) point2 = ~point2;
      if ($urandom_range(0, 700) == 0) async_reset();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
